// File: rtl/AHBCommon_pkg.sv
// Shared AHB-Lite encodings and the subordinate FSM state type.
package AHBCommon_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } trans_t;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } resp_t;

    typedef enum logic [1:0] {
        SUB_IDLE = 2'd0,
        SUB_WAIT = 2'd1,
        SUB_ERR1 = 2'd2,
        SUB_ERR2 = 2'd3
    } sub_state_t;

endpackage

// File: rtl/sram_byte_mem.sv
// Word-organised storage with a byte-enable write port and an asynchronous read port.
module sram_byte_mem #(
    parameter int Words = 256,
    parameter int Width = 32,
    parameter int AW    = (Words > 1) ? $clog2(Words) : 1
) (
    input  logic               clk,
    input  logic               we,
    input  logic [Width/8-1:0] be,
    input  logic [AW-1:0]      waddr,
    input  logic [Width-1:0]   wdata,
    input  logic [AW-1:0]      raddr,
    output logic [Width-1:0]   rdata
);

    logic [Width-1:0] mem [Words];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < Width / 8; b++) begin
                if (be[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sram_subordinate.sv
// AHB-Lite SRAM subordinate: optional wait states, two-cycle ERROR response,
// byte-lane writes committed at the end of the data phase.
module sram_subordinate
    import AHBCommon_pkg::*;
#(
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = 32,
    parameter int MemWords   = 256,
    parameter int WaitStates = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic [AddrWidth-1:0] addr,
    input  logic                 write,
    input  logic [2:0]           size,
    input  logic [1:0]           trans,
    input  logic [DataWidth-1:0] wData,
    input  logic                 ready,
    output logic                 readyOut,
    output logic                 resp,
    output logic [DataWidth-1:0] rData
);

    localparam int NB  = DataWidth / 8;
    localparam int OFF = $clog2(NB);
    localparam int MWW = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam int LW  = OFF + MWW;

    // Handshake: an address phase is taken when sel & ready & trans is NONSEQ/SEQ
    // and we are able to complete (readyOut=1). The data phase that follows ends on
    // the first cycle with readyOut=1; the bus holds ready=0 until then, so any
    // address presented in a stalled cycle is ignored.
    sub_state_t state, state_nx;
    logic [3:0]     cnt, cnt_nx;
    logic           act, act_nx;
    logic [LW-1:0]  addr_q;
    logic           write_q;
    logic [2:0]     size_q;

    logic                 accept;
    logic                 bad;
    logic [AddrWidth-1:0] word_idx;
    logic [AddrWidth-1:0] align_mask;
    logic [NB-1:0]        be;
    logic                 mem_we;
    logic [DataWidth-1:0] mem_rdata;

    assign accept = sel && ready && (trans == TRANS_NONSEQ || trans == TRANS_SEQ)
                    && (state == SUB_IDLE || state == SUB_ERR2);

    assign word_idx   = addr >> OFF;
    assign align_mask = AddrWidth'((1 << size) - 1);
    assign bad = (word_idx >= AddrWidth'(MemWords)) || (int'(size) > OFF)
                 || ((addr & align_mask) != '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SUB_IDLE;
            cnt     <= '0;
            act     <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            act   <= act_nx;
            if (accept) begin
                addr_q  <= addr[LW-1:0];
                write_q <= write;
                size_q  <= size;
            end
        end
    end

    // Next-state logic; act marks a good transfer whose data phase is pending
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        act_nx   = act;
        case (state)
            SUB_IDLE, SUB_ERR2: begin
                state_nx = SUB_IDLE;
                act_nx   = 1'b0;
                cnt_nx   = '0;
                if (accept) begin
                    if (bad) begin
                        state_nx = SUB_ERR1;
                    end else if (WaitStates > 0) begin
                        state_nx = SUB_WAIT;
                        cnt_nx   = 4'(WaitStates - 1);
                        act_nx   = 1'b1;
                    end else begin
                        act_nx = 1'b1;
                    end
                end
            end
            SUB_WAIT: begin
                if (cnt == '0) begin
                    state_nx = SUB_IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            SUB_ERR1: state_nx = SUB_ERR2;
            default:  state_nx = SUB_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        readyOut = 1'b1;
        resp     = RESP_OKAY;
        rData    = '0;
        mem_we   = 1'b0;
        case (state)
            SUB_WAIT: readyOut = 1'b0;
            SUB_ERR1: begin
                readyOut = 1'b0;
                resp     = RESP_ERROR;
            end
            SUB_ERR2: resp = RESP_ERROR;
            default: begin
                if (act) begin
                    mem_we = write_q;
                    if (!write_q) begin
                        rData = mem_rdata;
                    end
                end
            end
        endcase
    end

    // Little-endian lanes starting at the low address bits
    always_comb begin
        be = '0;
        for (int i = 0; i < NB; i++) begin
            if (i >= int'(addr_q[OFF-1:0]) && i < int'(addr_q[OFF-1:0]) + (1 << size_q)) begin
                be[i] = 1'b1;
            end
        end
    end

    sram_byte_mem #(
        .Words (MemWords),
        .Width (DataWidth),
        .AW    (MWW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (be),
        .waddr (addr_q[LW-1:OFF]),
        .wdata (wData),
        .raddr (addr_q[LW-1:OFF]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_sram_subordinate.sv
// Bench for sram_subordinate: three instances (0, 2 and 3 wait states) on one
// shared bus, driven by a pipelined master and checked against a byte-array model.
module tb_sram_subordinate;

    logic        clk;
    logic        reset;
    logic        bus_sel;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] wData;
    logic        ready;
    logic [1:0]  cur;
    logic [2:0]  sel_v;
    logic [2:0]  rdy_v;
    logic [2:0]  resp_v;
    logic [31:0] rdata_v [3];
    logic        resp_m;
    logic [31:0] rdata_m;

    int total = 0;
    int bad   = 0;
    int ws_of [3] = '{0, 2, 3};

    typedef struct {
        logic [31:0] a;
        bit          w;
        logic [2:0]  sz;
        logic [31:0] wd;
    } xfer_t;

    xfer_t       xq[$];
    logic [31:0] exp_q[$];
    bit          exp_err_q[$];
    logic [7:0]  mdl [3][1024];

    assign sel_v   = bus_sel ? (3'b001 << cur) : 3'b000;
    assign ready   = rdy_v[cur];
    assign resp_m  = resp_v[cur];
    assign rdata_m = rdata_v[cur];

    sram_subordinate #(.WaitStates(0)) u_ws0 (
        .clk(clk), .reset(reset), .sel(sel_v[0]), .addr(addr), .write(write), .size(size),
        .trans(trans), .wData(wData), .ready(ready), .readyOut(rdy_v[0]), .resp(resp_v[0]),
        .rData(rdata_v[0]));

    sram_subordinate #(.WaitStates(2)) u_ws2 (
        .clk(clk), .reset(reset), .sel(sel_v[1]), .addr(addr), .write(write), .size(size),
        .trans(trans), .wData(wData), .ready(ready), .readyOut(rdy_v[1]), .resp(resp_v[1]),
        .rData(rdata_v[1]));

    sram_subordinate #(.WaitStates(3)) u_ws3 (
        .clk(clk), .reset(reset), .sel(sel_v[2]), .addr(addr), .write(write), .size(size),
        .trans(trans), .wData(wData), .ready(ready), .readyOut(rdy_v[2]), .resp(resp_v[2]),
        .rData(rdata_v[2]));

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: decide error, apply writes, predict read word
    task automatic push_xfer(input int k, input logic [31:0] a, input bit w,
                             input logic [2:0] sz, input logic [31:0] wd);
        bit          err;
        int          nb;
        logic [31:0] word;
        xfer_t       x;
        nb   = 1 << sz;
        err  = (a / 4 >= 256) || (nb > 4) || (a % nb != 0);
        word = '0;
        if (!err && w) begin
            for (int b = 0; b < nb; b++) mdl[k][a + b] = wd[((a % 4) + b) * 8 +: 8];
        end
        if (!err && !w) begin
            for (int b = 0; b < 4; b++) word[b*8 +: 8] = mdl[k][(a & ~32'd3) + b];
        end
        x.a = a; x.w = w; x.sz = sz; x.wd = wd;
        xq.push_back(x);
        exp_err_q.push_back(err);
        exp_q.push_back(word);
    endtask

    task automatic drive_idle();
        bus_sel = 1'b0; trans = 2'd0; write = 1'b0; addr = '0; size = 3'd0;
    endtask

    // Pipelined master: next address goes out in the cycle the current data phase completes
    task automatic run_queue(input int k);
        xfer_t       dp;
        bit          have_dp;
        bit          dp_err;
        logic [31:0] dp_exp;
        int          lows;
        int          exp_lows;
        int          budget;
        cur = 2'(k);
        have_dp = 0; dp_err = 0; dp_exp = '0; lows = 0; budget = 0;
        while ((xq.size() > 0 || have_dp) && budget < 1000) begin
            @(negedge clk);
            budget++;
            if (have_dp) begin
                wData = dp.wd;
                if (ready !== 1'b1) begin
                    lows++;
                    total++;
                    if (resp_m !== dp_err || rdata_m !== 32'h0) begin
                        bad++;
                        $display("FAIL stall a=%h: resp=%b rdata=%h want resp=%b rdata=0",
                                 dp.a, resp_m, rdata_m, dp_err);
                    end
                end else begin
                    exp_lows = dp_err ? 1 : ws_of[k];
                    total++;
                    if (lows != exp_lows) begin
                        bad++;
                        $display("FAIL wait_cycles a=%h: got %0d want %0d", dp.a, lows, exp_lows);
                    end
                    total++;
                    if (resp_m !== dp_err) begin
                        bad++;
                        $display("FAIL resp a=%h: got %b want %b", dp.a, resp_m, dp_err);
                    end
                    if (dp_err || !dp.w) begin
                        total++;
                        if (rdata_m !== dp_exp) begin
                            bad++;
                            $display("FAIL rdata a=%h: got %h want %h", dp.a, rdata_m, dp_exp);
                        end
                    end
                    have_dp = 0;
                end
            end
            if (ready === 1'b1) begin
                if (xq.size() > 0) begin
                    dp = xq.pop_front();
                    dp_err = exp_err_q.pop_front();
                    dp_exp = exp_q.pop_front();
                    bus_sel = 1'b1; trans = 2'd2; addr = dp.a; write = dp.w; size = dp.sz;
                    have_dp = 1; lows = 0;
                end else begin
                    drive_idle();
                end
            end else begin
                // Junk address while stalled; must not be taken
                bus_sel = 1'b1; trans = 2'd2; write = 1'b1; size = 3'd2;
                addr = 32'($urandom_range(0, 15)) * 4;
            end
        end
        if (budget >= 1000) begin
            total++; bad++;
            $display("FAIL timeout dut=%0d: queue not drained", k);
        end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; drive_idle(); wData = '0; cur = 2'd0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rdy_v[k] !== 1'b1 || resp_v[k] !== 1'b0 || rdata_v[k] !== 32'h0) begin
                bad++;
                $display("FAIL reset dut=%0d: rdy=%b resp=%b rdata=%h want 1 0 0",
                         k, rdy_v[k], resp_v[k], rdata_v[k]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        push_xfer(0, 32'h10, 1, 3'd2, 32'hDEADBEEF);
        push_xfer(0, 32'h10, 0, 3'd2, 32'h0);
        push_xfer(0, 32'h10, 1, 3'd2, 32'h11223344);
        push_xfer(0, 32'h13, 1, 3'd0, 32'hAA000000);
        push_xfer(0, 32'h10, 0, 3'd2, 32'h0);
        run_queue(0);
    endtask

    task automatic test_wait_states();
        push_xfer(1, 32'h0, 1, 3'd2, 32'hCAFE0001);
        push_xfer(1, 32'h0, 0, 3'd2, 32'h0);
        push_xfer(1, 32'h6, 1, 3'd1, 32'hBEEF0000);
        push_xfer(1, 32'h4, 0, 3'd2, 32'h0);
        run_queue(1);
    endtask

    task automatic test_errors();
        push_xfer(0, 32'h400, 0, 3'd2, 32'h0);
        push_xfer(0, 32'h11, 1, 3'd1, 32'h55550000);
        push_xfer(0, 32'h10, 1, 3'd3, 32'h12345678);
        push_xfer(0, 32'h12, 1, 3'd2, 32'h87654321);
        push_xfer(0, 32'h10, 0, 3'd2, 32'h0);
        run_queue(0);
    endtask

    task automatic test_idle_busy();
        cur = 2'd0;
        @(negedge clk);
        bus_sel = 1'b1; trans = 2'd1; write = 1'b1; addr = 32'h10; size = 3'd2;
        @(negedge clk);
        wData = 32'h0;
        total++;
        if (rdy_v[0] !== 1'b1 || resp_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL busy: rdy=%b resp=%b want 1 0", rdy_v[0], resp_v[0]);
        end
        bus_sel = 1'b0; trans = 2'd2;
        @(negedge clk);
        total++;
        if (rdy_v[0] !== 1'b1 || resp_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL unselected: rdy=%b resp=%b want 1 0", rdy_v[0], resp_v[0]);
        end
        drive_idle();
        @(negedge clk);
        push_xfer(0, 32'h10, 0, 3'd2, 32'h0);
        run_queue(0);
    endtask

    task automatic test_reset_mid_wait();
        push_xfer(2, 32'h20, 1, 3'd2, 32'h5A5A1234);
        run_queue(2);
        bus_sel = 1'b1; trans = 2'd2; write = 1'b1; addr = 32'h20; size = 3'd2;
        @(negedge clk);
        drive_idle();
        wData = 32'hFFFF0000;
        total++;
        if (rdy_v[2] !== 1'b0) begin
            bad++;
            $display("FAIL wait_entry: rdy=%b want 0", rdy_v[2]);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (rdy_v[2] !== 1'b1 || resp_v[2] !== 1'b0 || rdata_v[2] !== 32'h0) begin
            bad++;
            $display("FAIL reset_abort: rdy=%b resp=%b rdata=%h want 1 0 0",
                     rdy_v[2], resp_v[2], rdata_v[2]);
        end
        reset = 1'b0;
        @(negedge clk);
        push_xfer(2, 32'h20, 0, 3'd2, 32'h0);
        run_queue(2);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [2:0]  sz;
        int          pick;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) push_xfer(k, 32'(i * 4), 1, 3'd2, $urandom);
            for (int i = 0; i < 40; i++) begin
                pick = $urandom_range(0, 19);
                sz = 3'($urandom_range(0, 2));
                a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                a = a & ~((32'd1 << sz) - 32'd1);
                if (pick == 0) a = 32'h400 + 32'($urandom_range(0, 63)) * 4;
                else if (pick == 1) sz = 3'd3;
                else if (pick == 2) begin a = 32'($urandom_range(0, 15) * 4 + 1); sz = 3'd1; end
                push_xfer(k, a, bit'($urandom_range(0, 1)), sz, $urandom);
            end
            run_queue(k);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_errors();
        test_idle_busy();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
